rally_ctrl: RTL
===============

Name: rally_ctrl

Overview:
- Match-level sequencer for the ball datapath.
- Decides when the ball is released for a serve and which side serves.
- Counts touches per side, flags an over-touch (4th consecutive touch by one side) and awards points on ground contact or over-touch.
- Keeps the score and declares the winner.
- Sits between the player/ball collision logic and the score display.
- Drives the ball controller's serve side, hold/release and over-touch inputs.

Parameters:
- NET_X, 512: x coordinate (pixels) of the net centre line.
- BALL_SIZE, 64: ball sprite width in pixels; the ball centre is ball_posx + BALL_SIZE/2.
- MAX_TOUCH, 3: legal touches per side per possession.
- WIN_SCORE, 15: points needed to win; must be ≤ 31.
- PAUSE_TICKS, 200: number of tick pulses held in POINT before the next serve.

Ports:
- clk  in  1  system clock (65 MHz).
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; starts or restarts a match.
- tick  in  1  one-cycle 100 Hz enable, used by the pause timer only.
- pl1_col  in  1  player 1/ball collision, level.
- pl2_col  in  1  player 2/ball collision, level.
- gnd_col  in  1  ball touching ground, level.
- ball_posx  in  12  ball left x coordinate in pixels.
- serve_side  out  1  0 = player 1 serves, 1 = player 2 serves.
- ball_release  out  1  1 in RALLY; 0 holds the ball at the serve position.
- ovr_touch  out  1  one-cycle pulse on over-touch.
- touch_cnt  out  2  touches by the current possessing side.
- last_side  out  1  side of the last counted touch.
- score_pl1  out  5  player 1 score.
- score_pl2  out  5  player 2 score.
- point_pulse  out  1  one-cycle pulse when a point is awarded.
- game_over  out  1  high in GAME_OVER.
- winner  out  1  0 = player 1, 1 = player 2; valid while game_over is high.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - All outputs 0: serve_side, ball_release, ovr_touch, touch_cnt, last_side, scores, point_pulse, game_over, winner.
  - Pause counter = 0; edge-detect registers = 0.
- Edge detection: pl1_col, pl2_col and gnd_col are registered once. An event is a rising edge (current = 1, previous = 0). Event at cycle N acts on registers at the N+1 edge.
- IDLE:
  - start -> SERVE.
  - Scores cleared, serve_side = 0.
- SERVE:
  - ball_release = 0, touch_cnt = 0.
  - A rising edge from the serving side's col -> RALLY, with touch_cnt = 1 and last_side = serve_side.
  - Col edges from the non-serving side are ignored.
  - gnd_col is ignored.
- RALLY, ball_release = 1. On each col edge:
  - Same side as last_side: touch_cnt + 1.
  - Other side: touch_cnt = 1, last_side = that side.
  - If the increment would exceed MAX_TOUCH: ovr_touch pulses for 1 cycle and the point goes to the opposite of last_side. touch_cnt saturates at 3 and is never written as 4.
  - Simultaneous pl1 and pl2 edges in the same cycle: no change to touch_cnt or last_side.
- RALLY, gnd_col edge:
  - Ball centre < NET_X -> point to player 2; otherwise -> point to player 1.
  - Ball centre is computed 13-bit unsigned, no wrap: ball_posx + BALL_SIZE/2.
  - Centre exactly equal to NET_X -> point to player 1.
- RALLY, over-touch and gnd_col edge in the same cycle: over-touch wins.
- Point award, single cycle:
  - Winner's score + 1.
  - point_pulse = 1.
  - serve_side = point winner.
  - ball_release = 0.
  - Pause counter cleared -> POINT.
- POINT:
  - Pause counter increments on tick. All col and ground edges are ignored.
  - When the counter reaches PAUSE_TICKS: if either score == WIN_SCORE -> GAME_OVER with winner set; else -> SERVE.
- GAME_OVER:
  - game_over = 1; scores frozen.
  - start -> scores cleared, serve_side = 0, game_over = 0 -> SERVE.
- start in SERVE, RALLY or POINT: restarts the match (scores and touches cleared, serve_side = 0, -> SERVE).
- Scores never exceed WIN_SCORE.
- rst_n asserted mid-rally: everything returns to IDLE immediately; no point is awarded.

Test Plan:
- Serve: reset, start, pl1_col edge -> ball_release = 1 next cycle, touch_cnt = 1, last_side = 0. A pl2_col edge while in SERVE -> no change.
- Ground on player 2's side: in RALLY with ball_posx = 700, gnd_col edge -> score_pl1 = 1, point_pulse for 1 cycle, serve_side = 0. After 200 ticks -> SERVE.
- Net boundary: ball_posx = 448 (centre = 480) with gnd_col -> point to player 2. ball_posx = 480 (centre = 512) -> point to player 1.
- Over-touch: four pl2_col edges with no pl1 touch between them -> ovr_touch pulses on the 4th, score_pl1 + 1, touch_cnt stays ≤ 3.
- Simultaneous events: over-touch edge and gnd_col edge in the same cycle -> exactly one point, awarded per over-touch. pl1 and pl2 edges together -> touch_cnt unchanged.
- Match end and reset: with score_pl2 = 14, award one point to player 2 -> after the pause, game_over = 1 and winner = 1. start -> scores 0, SERVE, serve_side = 0. rst_n low mid-rally -> IDLE with all outputs 0.

Source files
------------

// File: rtl/rally_ctrl.sv
// Match-level sequencer: serve/rally/point/game-over flow, per-side touch
// counting with over-touch detection, scoring and winner declaration.
module rally_ctrl #(
    parameter int unsigned NET_X       = 512,
    parameter int unsigned BALL_SIZE   = 64,
    parameter int unsigned MAX_TOUCH   = 3,
    parameter int unsigned WIN_SCORE   = 15,
    parameter int unsigned PAUSE_TICKS = 200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        tick,
    input  logic        pl1_col,
    input  logic        pl2_col,
    input  logic        gnd_col,
    input  logic [11:0] ball_posx,
    output logic        serve_side,
    output logic        ball_release,
    output logic        ovr_touch,
    output logic [1:0]  touch_cnt,
    output logic        last_side,
    output logic [4:0]  score_pl1,
    output logic [4:0]  score_pl2,
    output logic        point_pulse,
    output logic        game_over,
    output logic        winner
);

    localparam int unsigned PW = $clog2(PAUSE_TICKS + 1);

    typedef enum logic [2:0] {IDLE, SERVE, RALLY, POINT, GAME_OVER} state_t;

    state_t state, state_next;

    logic          pl1_q, pl2_q, gnd_q;
    logic          pl1_ev, pl2_ev, gnd_ev;
    logic [PW-1:0] pause_cnt, pause_next;
    logic [1:0]    touch_next;
    logic [4:0]    score1_next, score2_next;
    logic          last_next, serve_next, winner_next, ovr_next, point_next;
    logic          award, award_side;
    logic [12:0]   centre;

    assign pl1_ev = pl1_col & ~pl1_q;
    assign pl2_ev = pl2_col & ~pl2_q;
    assign gnd_ev = gnd_col & ~gnd_q;
    assign centre = {1'b0, ball_posx} + 13'(BALL_SIZE / 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        touch_next  = touch_cnt;
        last_next   = last_side;
        serve_next  = serve_side;
        score1_next = score_pl1;
        score2_next = score_pl2;
        winner_next = winner;
        pause_next  = pause_cnt;
        ovr_next    = 1'b0;
        point_next  = 1'b0;
        award       = 1'b0;
        award_side  = 1'b0;
        if (start) begin
            state_next  = SERVE;
            score1_next = '0;
            score2_next = '0;
            serve_next  = 1'b0;
            touch_next  = '0;
            last_next   = 1'b0;
            winner_next = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                SERVE: begin
                    touch_next = '0;
                    if (serve_side ? pl2_ev : pl1_ev) begin
                        state_next = RALLY;
                        touch_next = 2'd1;
                        last_next  = serve_side;
                    end
                end
                RALLY: begin
                    // Simultaneous pl1/pl2 edges cancel out; pl2_ev doubles as the touching side.
                    if (pl1_ev ^ pl2_ev) begin
                        if (pl2_ev == last_side) begin
                            if (touch_cnt >= 2'(MAX_TOUCH)) begin
                                ovr_next   = 1'b1;
                                award      = 1'b1;
                                award_side = ~last_side;
                            end else begin
                                touch_next = touch_cnt + 2'd1;
                            end
                        end else begin
                            touch_next = 2'd1;
                            last_next  = pl2_ev;
                        end
                    end
                    if (!award && gnd_ev) begin
                        award      = 1'b1;
                        award_side = (centre < 13'(NET_X));
                    end
                    if (award) begin
                        if (award_side) begin
                            if (score_pl2 < 5'(WIN_SCORE)) score2_next = score_pl2 + 5'd1;
                        end else begin
                            if (score_pl1 < 5'(WIN_SCORE)) score1_next = score_pl1 + 5'd1;
                        end
                        point_next = 1'b1;
                        serve_next = award_side;
                        pause_next = '0;
                        state_next = POINT;
                    end
                end
                POINT: begin
                    if (pause_cnt == PW'(PAUSE_TICKS)) begin
                        if (score_pl1 == 5'(WIN_SCORE) || score_pl2 == 5'(WIN_SCORE)) begin
                            state_next  = GAME_OVER;
                            winner_next = (score_pl2 == 5'(WIN_SCORE));
                        end else begin
                            state_next = SERVE;
                            touch_next = '0;
                        end
                    end else if (tick) begin
                        pause_next = pause_cnt + PW'(1);
                    end
                end
                GAME_OVER: ;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pl1_q       <= 1'b0;
            pl2_q       <= 1'b0;
            gnd_q       <= 1'b0;
            pause_cnt   <= '0;
            touch_cnt   <= '0;
            last_side   <= 1'b0;
            serve_side  <= 1'b0;
            score_pl1   <= '0;
            score_pl2   <= '0;
            winner      <= 1'b0;
            ovr_touch   <= 1'b0;
            point_pulse <= 1'b0;
        end else begin
            pl1_q       <= pl1_col;
            pl2_q       <= pl2_col;
            gnd_q       <= gnd_col;
            pause_cnt   <= pause_next;
            touch_cnt   <= touch_next;
            last_side   <= last_next;
            serve_side  <= serve_next;
            score_pl1   <= score1_next;
            score_pl2   <= score2_next;
            winner      <= winner_next;
            ovr_touch   <= ovr_next;
            point_pulse <= point_next;
        end
    end

    always_comb begin
        ball_release = (state == RALLY);
        game_over    = (state == GAME_OVER);
    end

endmodule
